lock_seq_ctrl: RTL and testbench

- Sequencing controller for the 3-digit combination lock datapath.
- Turns raw button levels into single-cycle actions and holds the entry buffer, stored code, attempt counter and timers.
- Decides locked/open/set-code/lockout state and drives the display cursor, digit value and status lines.
- Sits between the button inputs and the N1..N6 display/indicator logic.

---
 rtl/lock_pkg.sv | 26 ++
 rtl/lock_seq_ctrl_if.sv | 25 ++
 rtl/btn_edge.sv | 28 ++
 rtl/lock_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lock_seq_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock sequencing controller.
package lock_pkg;

    typedef enum logic [1:0] {
        StLocked,
        StOpen,
        StSet,
        StLockout
    } state_e;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Higher index means higher priority when presses coincide.
    localparam int unsigned NUM_BTN     = 5;
    localparam int unsigned BTN_MOD10   = 0;
    localparam int unsigned BTN_MOD3    = 1;
    localparam int unsigned BTN_CONFIRM = 2;
    localparam int unsigned BTN_ENTER   = 3;
    localparam int unsigned BTN_MODE    = 4;

    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
        return (d >= BCD_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/lock_seq_ctrl_if.sv
// Button inputs and display/status outputs of the lock sequencing controller.
interface lock_seq_ctrl_if;
    logic       mod3_btn;
    logic       mod10_btn;
    logic       confirm;
    logic       enter;
    logic       mode;
    logic [1:0] digit_sel;
    logic [3:0] digit_val;
    logic       unlocked;
    logic       set_mode;
    logic       lockout;
    logic       err;
    logic [1:0] tries_left;

    modport master (
        output mod3_btn, mod10_btn, confirm, enter, mode,
        input  digit_sel, digit_val, unlocked, set_mode, lockout, err, tries_left
    );

    modport slave (
        input  mod3_btn, mod10_btn, confirm, enter, mode,
        output digit_sel, digit_val, unlocked, set_mode, lockout, err, tries_left
    );
endinterface

// File: rtl/btn_edge.sv
// Registers a vector of button levels and flags a single-cycle press on each rising edge.
module btn_edge
    import lock_pkg::*;
#(
    parameter int unsigned WIDTH = NUM_BTN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] btn_i,
    output logic [WIDTH-1:0] press_o
);

    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= btn_i;
            prev_q <= cur_q;
        end
    end

    always_comb press_o = cur_q & ~prev_q;

endmodule

// File: rtl/lock_seq_ctrl.sv
// Combination-lock sequencer: button qualification, entry buffer, stored code,
// attempt counting and open/lockout timers with registered status outputs.
module lock_seq_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYC    = 8,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 12'h000
) (
    input  logic           enable,
    input  logic           rst_btn,
    lock_seq_ctrl_if.slave bus_io
);

    localparam int unsigned CODE_W  = DIGITS * DIGIT_W;
    localparam int unsigned TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_CYC);
    localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(LOCKOUT_CYC);
    localparam logic [1:0]       TRIES_INIT = 2'(MAX_TRIES);
    localparam logic [1:0]       CUR_LAST   = 2'(DIGITS - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;

    state_e             state_q, state_d;
    logic [1:0]         cur_q, cur_d;
    logic [CODE_W-1:0]  buf_q, buf_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [1:0]         tries_q, tries_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               err_q, err_d;
    logic [DIGIT_W-1:0] dval_q, dval_d;
    logic               unlocked_q, set_mode_q, lockout_q;

    logic act_mode, act_enter, act_confirm, act_mod3, act_mod10;
    logic [TMR_W-1:0] tmr_dec;

    always_comb begin
        btn_raw              = '0;
        btn_raw[BTN_MOD10]   = bus_io.mod10_btn;
        btn_raw[BTN_MOD3]    = bus_io.mod3_btn;
        btn_raw[BTN_CONFIRM] = bus_io.confirm;
        btn_raw[BTN_ENTER]   = bus_io.enter;
        btn_raw[BTN_MODE]    = bus_io.mode;
    end

    btn_edge #(
        .WIDTH(NUM_BTN)
    ) u_btn_edge (
        .clk_i  (enable),
        .rst_ni (rst_btn),
        .btn_i  (btn_raw),
        .press_o(btn_press)
    );

    // Only the highest-priority press of a cycle survives; the rest are dropped.
    always_comb begin
        act_mode    = btn_press[BTN_MODE];
        act_enter   = !act_mode && btn_press[BTN_ENTER];
        act_confirm = !act_mode && btn_press[BTN_CONFIRM];
        act_mod3    = !act_mode && !btn_press[BTN_ENTER] && !btn_press[BTN_CONFIRM]
                      && btn_press[BTN_MOD3];
        act_mod10   = !act_mode && !btn_press[BTN_ENTER] && !btn_press[BTN_CONFIRM]
                      && !btn_press[BTN_MOD3] && btn_press[BTN_MOD10];
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        buf_d   = buf_q;
        code_d  = code_q;
        tries_d = tries_q;
        tmr_d   = tmr_q;
        err_d   = 1'b0;
        tmr_dec = (tmr_q == '0) ? '0 : tmr_q - TMR_W'(1);

        if (state_q == StLocked || state_q == StSet) begin
            if (act_mod3) begin
                cur_d = (cur_q >= CUR_LAST) ? 2'd0 : cur_q + 2'd1;
            end
            if (act_mod10) begin
                buf_d[cur_q*DIGIT_W +: DIGIT_W] = bcd_inc(buf_q[cur_q*DIGIT_W +: DIGIT_W]);
            end
        end

        case (state_q)
            StLocked: begin
                if (act_enter) begin
                    if (buf_q == code_q) begin
                        state_d = StOpen;
                        tmr_d   = OPEN_LOAD;
                        tries_d = TRIES_INIT;
                    end else begin
                        err_d   = 1'b1;
                        tries_d = tries_q - 2'd1;
                        if (tries_q <= 2'd1) begin
                            state_d = StLockout;
                            tmr_d   = LOCK_LOAD;
                        end
                    end
                end
            end
            StOpen: begin
                if (act_mode) begin
                    state_d = StSet;
                end else begin
                    tmr_d = tmr_dec;
                    if (tmr_dec == '0) state_d = StLocked;
                end
            end
            StSet: begin
                if (act_mode) begin
                    state_d = StOpen;
                    tmr_d   = OPEN_LOAD;
                end else if (act_confirm) begin
                    code_d  = buf_q;
                    state_d = StOpen;
                    tmr_d   = OPEN_LOAD;
                end
            end
            StLockout: begin
                tmr_d = tmr_dec;
                if (tmr_dec == '0) begin
                    state_d = StLocked;
                    tries_d = TRIES_INIT;
                end
            end
            default: state_d = StLocked;
        endcase

        if (state_d != state_q) begin
            cur_d = '0;
            buf_d = '0;
        end

        dval_d = buf_d[cur_d*DIGIT_W +: DIGIT_W];
    end

    always_ff @(posedge enable or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q    <= StLocked;
            cur_q      <= '0;
            buf_q      <= '0;
            code_q     <= DEFAULT_CODE;
            tries_q    <= TRIES_INIT;
            tmr_q      <= '0;
            err_q      <= 1'b0;
            dval_q     <= '0;
            unlocked_q <= 1'b0;
            set_mode_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            buf_q      <= buf_d;
            code_q     <= code_d;
            tries_q    <= tries_d;
            tmr_q      <= tmr_d;
            err_q      <= err_d;
            dval_q     <= dval_d;
            unlocked_q <= (state_d == StOpen) || (state_d == StSet);
            set_mode_q <= (state_d == StSet);
            lockout_q  <= (state_d == StLockout);
        end
    end

    assign bus_io.digit_sel  = cur_q;
    assign bus_io.digit_val  = dval_q;
    assign bus_io.unlocked   = unlocked_q;
    assign bus_io.set_mode   = set_mode_q;
    assign bus_io.lockout    = lockout_q;
    assign bus_io.err        = err_q;
    assign bus_io.tries_left = tries_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl with DEFAULT_CODE=12'h123 (digit0=3, digit1=2, digit2=1).
module tb_lock_seq_ctrl;

    localparam logic [4:0] M_MOD10 = 5'b00001;
    localparam logic [4:0] M_MOD3  = 5'b00010;
    localparam logic [4:0] M_CFM   = 5'b00100;
    localparam logic [4:0] M_ENT   = 5'b01000;
    localparam logic [4:0] M_MODE  = 5'b10000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lock_seq_ctrl_if bus ();

    lock_seq_ctrl #(
        .DIGITS      (3),
        .MAX_TRIES   (3),
        .OPEN_CYC    (8),
        .LOCKOUT_CYC (16),
        .DEFAULT_CODE(12'h123)
    ) dut (
        .enable (clk),
        .rst_btn(rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] m);
        {bus.mode, bus.enter, bus.confirm, bus.mod3_btn, bus.mod10_btn} = m;
    endtask

    // Button held for one cycle; outputs reflect the action on return.
    task automatic press(input logic [4:0] m);
        set_btns(m);
        tick();
        set_btns(5'b0);
        tick();
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2);
        repeat (d0) press(M_MOD10);
        press(M_MOD3);
        repeat (d1) press(M_MOD10);
        press(M_MOD3);
        repeat (d2) press(M_MOD10);
    endtask

    task automatic do_reset();
        set_btns(5'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_relock(input string tag);
        int n;
        n = 0;
        while (bus.unlocked && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.unlocked !== 1'b0) begin
            errors++;
            $display("FAIL %s_relock: unlocked=%0b after %0d cycles, want 0", tag, bus.unlocked, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.digit_sel, bus.digit_val, bus.unlocked, bus.set_mode, bus.lockout, bus.err,
             bus.tries_left} !== {2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL reset_outputs: sel=%0d val=%0d unl=%0b set=%0b lo=%0b err=%0b tries=%0d, want all 0 tries=3",
                     bus.digit_sel, bus.digit_val, bus.unlocked, bus.set_mode, bus.lockout,
                     bus.err, bus.tries_left);
        end
        press(M_ENT);
        checks++;
        if ({bus.err, bus.tries_left, bus.unlocked, bus.lockout} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_enter: err=%0b tries=%0d unl=%0b lo=%0b, want 1 2 0 0",
                     bus.err, bus.tries_left, bus.unlocked, bus.lockout);
        end
        tick();
        checks++;
        if ({bus.err, bus.tries_left} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL err_pulse_width: err=%0b tries=%0d, want 0 2", bus.err, bus.tries_left);
        end
    endtask

    task automatic test_entry();
        int n;
        do_reset();
        enter_code(3, 2, 1);
        checks++;
        if ({bus.digit_sel, bus.digit_val} !== {2'd2, 4'd1}) begin
            errors++;
            $display("FAIL entry_buffer: sel=%0d val=%0d, want 2 1", bus.digit_sel, bus.digit_val);
        end
        press(M_ENT);
        checks++;
        if ({bus.unlocked, bus.err, bus.digit_sel, bus.tries_left} !== {1'b1, 1'b0, 2'd0, 2'd3}) begin
            errors++;
            $display("FAIL entry_open: unl=%0b err=%0b sel=%0d tries=%0d, want 1 0 0 3",
                     bus.unlocked, bus.err, bus.digit_sel, bus.tries_left);
        end
        n = 0;
        while (bus.unlocked && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL open_duration: got %0d cycles, want 8", n);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        press(M_MOD3);
        checks++;
        if (bus.digit_sel !== 2'd1) begin
            errors++;
            $display("FAIL cursor_step: sel=%0d, want 1", bus.digit_sel);
        end
        press(M_MOD3);
        press(M_MOD3);
        checks++;
        if (bus.digit_sel !== 2'd0) begin
            errors++;
            $display("FAIL cursor_wrap: sel=%0d, want 0", bus.digit_sel);
        end
        repeat (9) press(M_MOD10);
        checks++;
        if (bus.digit_val !== 4'd9) begin
            errors++;
            $display("FAIL digit_nine: val=%0d, want 9", bus.digit_val);
        end
        press(M_MOD10);
        checks++;
        if (bus.digit_val !== 4'd0) begin
            errors++;
            $display("FAIL digit_wrap: val=%0d, want 0", bus.digit_val);
        end
        set_btns(M_MOD3);
        repeat (5) tick();
        set_btns(5'b0);
        tick();
        checks++;
        if (bus.digit_sel !== 2'd1) begin
            errors++;
            $display("FAIL hold_one_press: sel=%0d, want 1", bus.digit_sel);
        end
    endtask

    task automatic test_lockout();
        int n;
        do_reset();
        press(M_ENT);
        press(M_ENT);
        checks++;
        if ({bus.tries_left, bus.lockout} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL two_wrong: tries=%0d lo=%0b, want 1 0", bus.tries_left, bus.lockout);
        end
        press(M_ENT);
        checks++;
        if ({bus.lockout, bus.err, bus.tries_left, bus.unlocked} !== {1'b1, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL lockout_entry: lo=%0b err=%0b tries=%0d unl=%0b, want 1 1 0 0",
                     bus.lockout, bus.err, bus.tries_left, bus.unlocked);
        end
        n = 0;
        while (bus.lockout && n < 40) begin
            n++;
            bus.enter    = 1'b1;
            bus.mod3_btn = (n < 10) && n[0];
            tick();
        end
        bus.mod3_btn = 1'b0;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL lockout_duration: got %0d cycles, want 16", n);
        end
        checks++;
        if ({bus.lockout, bus.tries_left, bus.digit_sel} !== {1'b0, 2'd3, 2'd0}) begin
            errors++;
            $display("FAIL lockout_exit: lo=%0b tries=%0d sel=%0d, want 0 3 0",
                     bus.lockout, bus.tries_left, bus.digit_sel);
        end
        repeat (3) tick();
        checks++;
        if ({bus.tries_left, bus.err} !== {2'd3, 1'b0}) begin
            errors++;
            $display("FAIL held_enter_silent: tries=%0d err=%0b, want 3 0", bus.tries_left, bus.err);
        end
        bus.enter = 1'b0;
        tick();
        repeat (3) press(M_ENT);
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.lockout, bus.tries_left} !== {1'b0, 2'd3}) begin
            errors++;
            $display("FAIL async_reset_lockout: lo=%0b tries=%0d, want 0 3", bus.lockout, bus.tries_left);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_code_change();
        do_reset();
        enter_code(3, 2, 1);
        press(M_ENT);
        press(M_MODE);
        checks++;
        if ({bus.set_mode, bus.unlocked} !== 2'b11) begin
            errors++;
            $display("FAIL enter_set: set=%0b unl=%0b, want 1 1", bus.set_mode, bus.unlocked);
        end
        enter_code(4, 5, 6);
        checks++;
        if (bus.digit_val !== 4'd6) begin
            errors++;
            $display("FAIL set_entry: val=%0d, want 6", bus.digit_val);
        end
        press(M_CFM);
        checks++;
        if ({bus.set_mode, bus.unlocked} !== 2'b01) begin
            errors++;
            $display("FAIL confirm_open: set=%0b unl=%0b, want 0 1", bus.set_mode, bus.unlocked);
        end
        wait_relock("confirm");
        enter_code(4, 5, 6);
        press(M_ENT);
        checks++;
        if ({bus.unlocked, bus.err} !== 2'b10) begin
            errors++;
            $display("FAIL new_code_opens: unl=%0b err=%0b, want 1 0", bus.unlocked, bus.err);
        end
        wait_relock("new_code");
        enter_code(1, 2, 3);
        press(M_ENT);
        checks++;
        if ({bus.unlocked, bus.err} !== 2'b01) begin
            errors++;
            $display("FAIL old_order_rejected: unl=%0b err=%0b, want 0 1", bus.unlocked, bus.err);
        end
        do_reset();
        enter_code(4, 5, 6);
        press(M_ENT);
        checks++;
        if ({bus.unlocked, bus.err} !== 2'b01) begin
            errors++;
            $display("FAIL reset_drops_code: unl=%0b err=%0b, want 0 1", bus.unlocked, bus.err);
        end
        do_reset();
        enter_code(3, 2, 1);
        press(M_ENT);
        press(M_MODE);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.set_mode, bus.unlocked} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_set: set=%0b unl=%0b, want 0 0", bus.set_mode, bus.unlocked);
        end
        rst_n = 1'b1;
        tick();
        enter_code(3, 2, 1);
        press(M_ENT);
        checks++;
        if (bus.unlocked !== 1'b1) begin
            errors++;
            $display("FAIL default_restored: unl=%0b, want 1", bus.unlocked);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        enter_code(3, 2, 1);
        press(M_ENT);
        press(M_MODE | M_MOD10);
        checks++;
        if ({bus.set_mode, bus.digit_val} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL mode_beats_mod10: set=%0b val=%0d, want 1 0", bus.set_mode, bus.digit_val);
        end
        press(M_MODE);
        checks++;
        if ({bus.set_mode, bus.unlocked} !== 2'b01) begin
            errors++;
            $display("FAIL set_abort: set=%0b unl=%0b, want 0 1", bus.set_mode, bus.unlocked);
        end
        do_reset();
        press(M_MOD3 | M_MOD10);
        checks++;
        if ({bus.digit_sel, bus.digit_val} !== {2'd1, 4'd0}) begin
            errors++;
            $display("FAIL mod3_beats_mod10: sel=%0d val=%0d, want 1 0", bus.digit_sel, bus.digit_val);
        end
        press(M_MOD3);
        press(M_MOD3);
        checks++;
        if ({bus.digit_sel, bus.digit_val} !== {2'd0, 4'd0}) begin
            errors++;
            $display("FAIL digit0_untouched: sel=%0d val=%0d, want 0 0", bus.digit_sel, bus.digit_val);
        end
        press(M_ENT | M_MOD10);
        checks++;
        if ({bus.err, bus.digit_val, bus.tries_left} !== {1'b1, 4'd0, 2'd2}) begin
            errors++;
            $display("FAIL enter_beats_mod10: err=%0b val=%0d tries=%0d, want 1 0 2",
                     bus.err, bus.digit_val, bus.tries_left);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_btns(5'b0);
        tick();
        test_reset();
        test_entry();
        test_wrap();
        test_lockout();
        test_code_change();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
